counter_checker: RTL
====================

COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the width of the observed counter value.
REQ-002 The module SHALL have parameter ECW, default 8, giving the width of the error counter.
REQ-003 The module SHALL have port clk  input  1  the single clock; all logic updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port en  input  1  check enable; 0 holds the checker idle.
REQ-006 The module SHALL have port dut_rst  input  1  the observed counter's active-high reset.
REQ-007 The module SHALL have port ld  input  1  the observed counter's load strobe.
REQ-008 The module SHALL have port ldvalue  input  WIDTH  the observed counter's load value.
REQ-009 The module SHALL have port dout  input  WIDTH  the observed counter's output.
REQ-010 The module SHALL have port synced  output  1  high while in CHECK.
REQ-011 The module SHALL have port err  output  1  one-cycle mismatch pulse.
REQ-012 The module SHALL have port err_sticky  output  1  high once any mismatch has occurred.
REQ-013 The module SHALL have port err_cnt  output  ECW  saturating mismatch count.
REQ-014 The module SHALL have port chk_cnt  output  16  saturating count of comparisons performed.

Function
REQ-015 The checker SHALL sample en, dut_rst, ld, ldvalue and dout on every rising clk edge.
REQ-016 The checker SHALL hold an internal WIDTH-bit model register named exp.
REQ-017 The next-value rule SHALL be nxt(v) = 0 if dut_rst; else ldvalue if ld; else (v+1) mod 2^WIDTH, with priority dut_rst > ld > increment.
REQ-018 Increment SHALL wrap from 2^WIDTH-1 to 0 without flagging an error.
REQ-019 The FSM SHALL have three states: IDLE, SYNC and CHECK.
REQ-020 In IDLE with en=0, the FSM SHALL stay in IDLE and perform no compare.
REQ-021 In IDLE with en=1, the FSM SHALL go to SYNC and perform no compare.
REQ-022 In SYNC, the checker SHALL load exp <= nxt(dout), perform no compare, and go to CHECK if en=1, else to IDLE.
REQ-023 In CHECK with en=1, the checker SHALL compare dout with exp and increment chk_cnt.
REQ-024 In CHECK on a match, the checker SHALL load exp <= nxt(exp).
REQ-025 In CHECK on a mismatch, the checker SHALL assert err, load exp <= nxt(dout) (resynchronise), set err_sticky and increment err_cnt.
REQ-026 The resynchronise rule SHALL cause one wrong value to produce exactly one err.
REQ-027 In CHECK with en=0, the FSM SHALL go to IDLE with no compare.
REQ-028 err SHALL be registered: high for exactly the one cycle following the mismatching sample edge, and low otherwise.
REQ-029 Comparison latency SHALL be 1 cycle: dout sampled at edge k SHALL be judged against a prediction built from ld, dut_rst and ldvalue sampled at edge k-1.
REQ-030 err_cnt SHALL saturate at 2^ECW-1, and chk_cnt SHALL saturate at 65535; neither SHALL wrap.
REQ-031 err_sticky, err_cnt and chk_cnt SHALL be retained across en deassertion and cleared only by rst.
REQ-032 synced SHALL be 1 exactly when the state is CHECK.
REQ-033 If dut_rst and ld are both high in the same cycle, the checker SHALL expect 0 next.
REQ-034 If en drops and rises again, the checker SHALL pass through SYNC again, so the first sample after re-enable is never compared.

Reset
REQ-035 When rst=0 at a rising edge, the checker SHALL set state=IDLE, exp=0, synced=0, err=0, err_sticky=0, err_cnt=0 and chk_cnt=0.
REQ-036 Reset SHALL take priority over all other inputs.
REQ-037 Reset asserted mid-CHECK SHALL abort checking with no err pulse in the same or the following cycle.
REQ-038 After rst returns to 1, the checker SHALL need en=1 to pass IDLE -> SYNC -> CHECK before the first compare.

Verification
REQ-039 Scenario (free-run): en=1, dout counts 3,4,...,15,0,1 with ld=0 -> synced=1 from the third edge, err never asserts, and chk_cnt increments by 1 per cycle.
REQ-040 Scenario (load): in CHECK, ld=1 with ldvalue=9 while dout=5, then dout=9 -> no err; next dout=10 -> no err.
REQ-041 Scenario (single fault): expected dout 7, driven 2, then 3,4 -> err is high for exactly one cycle, err_cnt=1, err_sticky=1, and no later err.
REQ-042 Scenario (dut_rst/ld collision): dut_rst=1 and ld=1 with ldvalue=12 in the same cycle, then dout=0 -> no err; dout=12 instead -> one err.
REQ-043 Scenario (saturation): ECW=2, inject 5 single faults -> err_cnt stays at 3 and err pulses 5 times.
REQ-044 Scenario (reset mid-check): rst=0 for 1 cycle in CHECK after an error -> all outputs are 0 next cycle, and the first compare occurs 2 edges after rst=1 with en=1.

Source files
------------

// File: rtl/counter_checker.sv
// counter_checker: tracks a WIDTH-bit up/load/reset counter and flags each divergence once.
module counter_checker #(
  parameter int WIDTH = 4,
  parameter int ECW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dut_rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldvalue,
  input  logic [WIDTH-1:0] dout,
  output logic             synced,
  output logic             err,
  output logic             err_sticky,
  output logic [ECW-1:0]   err_cnt,
  output logic [15:0]      chk_cnt
);
  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] w_nxt_dout;
  logic [WIDTH-1:0] w_nxt_exp;
  logic             w_match;
  assign w_nxt_dout = dut_rst ? '0 : ld ? ldvalue : dout + WIDTH'(1);
  assign w_nxt_exp  = dut_rst ? '0 : ld ? ldvalue : r_exp + WIDTH'(1);
  assign w_match    = (dout == r_exp);
  assign synced     = (r_state == CHECK);
  // A mismatch reloads the model from the observed value, so one bad sample costs one err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_exp      <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      chk_cnt    <= '0;
    end else begin
      err <= 1'b0;
      case (r_state)
        IDLE: if (en) r_state <= SYNC;
        SYNC: begin
          r_exp   <= w_nxt_dout;
          r_state <= en ? CHECK : IDLE;
        end
        CHECK: begin
          if (!en) begin
            r_state <= IDLE;
          end else begin
            if (~&chk_cnt) chk_cnt <= chk_cnt + 16'd1;
            if (w_match) begin
              r_exp <= w_nxt_exp;
            end else begin
              r_exp      <= w_nxt_dout;
              err        <= 1'b1;
              err_sticky <= 1'b1;
              if (~&err_cnt) err_cnt <= err_cnt + ECW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
